// File: rtl/aes_decrypt_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_decrypt_iter (with aes_decrypt_iter_pkg, Sub_bytes,          |
// |            Inv_sub_bytes)                                                   |
// | Brief    : Iterative AES-128 inverse cipher, one round per clock, on-the-fly|
// |            reverse key schedule. AES_DEC_KEY_EXPAND_EN: key is cipher key.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

package aes_decrypt_iter_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gfMul(s, s);
      r = gfMul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] sboxFwd(input logic [7:0] b);
    logic [7:0] i;
    i = gfInv(b);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sboxInv(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gfInv(t);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Byte n sits at s[127-8n -: 8], n = row + 4*col; row r rotates right by r.
  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] invMixCol(input logic [31:0] col);
    logic [7:0] a[4], m9[4], mb[4], md[4], me[4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = invMixCol(s[127-32*c -: 32]);
    end
    return o;
  endfunction

endpackage

module Sub_bytes #(
  parameter int N_BYTES = 4
) (
  input  logic [8*N_BYTES-1:0] dataIn,
  output logic [8*N_BYTES-1:0] dataOut
);
  import aes_decrypt_iter_pkg::*;

  generate
    for (genvar i = 0; i < N_BYTES; i++) begin : g_byte
      assign dataOut[8*i +: 8] = sboxFwd(dataIn[8*i +: 8]);
    end
  endgenerate
endmodule

module Inv_sub_bytes #(
  parameter int N_BYTES = 16
) (
  input  logic [8*N_BYTES-1:0] dataIn,
  output logic [8*N_BYTES-1:0] dataOut
);
  import aes_decrypt_iter_pkg::*;

  generate
    for (genvar i = 0; i < N_BYTES; i++) begin : g_byte
      assign dataOut[8*i +: 8] = sboxInv(dataIn[8*i +: 8]);
    end
  endgenerate
endmodule

module aes_decrypt_iter #(
  parameter int OUT_CLEAR = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);
  import aes_decrypt_iter_pkg::*;

`ifdef AES_DEC_KEY_EXPAND_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2, EXPAND = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t       r_state;
  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [3:0]   r_rnd;

  logic         w_accept;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [7:0]   w_rcon;
  logic [31:0]  w_subIn, w_subOut;
  logic [127:0] w_rkPrev;
  logic [127:0] w_shifted, w_invSub, w_added, w_mixed;

  assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
  assign w_rcon = rcon(r_rnd + 4'd1);

  // One S-box word serves both schedules: reverse uses w3^w2, forward uses w3.
`ifdef AES_DEC_KEY_EXPAND_EN
  logic [127:0] w_rkNext;
  logic [31:0]  w_f0, w_f1, w_f2;
  assign w_subIn  = (r_state == EXPAND) ? w_w3 : (w_w3 ^ w_w2);
  assign w_f0     = w_w0 ^ w_subOut ^ {w_rcon, 24'h0};
  assign w_f1     = w_w1 ^ w_f0;
  assign w_f2     = w_w2 ^ w_f1;
  assign w_rkNext = {w_f0, w_f1, w_f2, w_w3 ^ w_f2};
`else
  assign w_subIn  = w_w3 ^ w_w2;
`endif

  Sub_bytes #(.N_BYTES(4)) u_subWord (
    .dataIn  ({w_subIn[23:0], w_subIn[31:24]}),
    .dataOut (w_subOut)
  );

  assign w_rkPrev = {w_w0 ^ w_subOut ^ {w_rcon, 24'h0}, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};

  assign w_shifted = invShiftRows(r_st);

  Inv_sub_bytes #(.N_BYTES(16)) u_invSub (
    .dataIn  (w_shifted),
    .dataOut (w_invSub)
  );

  assign w_added = w_invSub ^ w_rkPrev;
  assign w_mixed = invMixColumns(w_added);

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out       = ((OUT_CLEAR != 0) && !out_valid) ? '0 : r_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_st    <= '0;
      r_rk    <= '0;
      r_rnd   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_rk <= key;
`ifdef AES_DEC_KEY_EXPAND_EN
            r_st    <= in;
            r_rnd   <= 4'd0;
            r_state <= EXPAND;
`else
            r_st    <= in ^ key;
            r_rnd   <= 4'd9;
            r_state <= ROUND;
`endif
          end else if ((r_state == DONE) && out_ready) begin
            r_state <= IDLE;
          end
        end
        ROUND: begin
          r_rk <= w_rkPrev;
          if (r_rnd == 4'd0) begin
            r_st    <= w_added;
            r_state <= DONE;
          end else begin
            r_st  <= w_mixed;
            r_rnd <= r_rnd - 4'd1;
          end
        end
`ifdef AES_DEC_KEY_EXPAND_EN
        // Ten forward steps reach the round-10 key, then one whitening cycle.
        EXPAND: begin
          if (r_rnd == 4'd10) begin
            r_st    <= r_st ^ r_rk;
            r_rnd   <= 4'd9;
            r_state <= ROUND;
          end else begin
            r_rk  <= w_rkNext;
            r_rnd <= r_rnd + 4'd1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_decrypt_iter                                             |
// | Brief    : Self-checking bench for aes_decrypt_iter against a table-based  |
// |            FIPS-197 inverse cipher model. Honours AES_DEC_KEY_EXPAND_EN.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [127:0] din = '0;
  logic [127:0] dkey = '0;
  logic [127:0] dout;

  int nTests = 0;
  int nFail  = 0;

  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_DEC_KEY_EXPAND_EN
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam int           LAT = 21;
`else
  localparam logic [127:0] K1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KB  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam int           LAT = 10;
`endif

  always #5 clk = ~clk;

  aes_decrypt_iter #(.OUT_CLEAR(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .key       (dkey),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .busy      (busy)
  );

  logic [7:0] sbox[256];
  logic [7:0] invSbox[256];

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Tables built by walking generator 3 and its inverse around the group.
  task automatic initBoxes();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) invSbox[sbox[i]] = 8'(i);
  endtask

  function automatic logic [31:0] schedF(input logic [31:0] w, input int i);
    logic [31:0] r;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int j = 1; j < i; j++) rc = gmul(rc, 8'h02);
    r = {w[23:0], w[31:24]};
    return {sbox[r[31:24]] ^ rc, sbox[r[23:16]], sbox[r[15:8]], sbox[r[7:0]]};
  endfunction

  function automatic logic [127:0] modelDecrypt(input logic [127:0] ct, input logic [127:0] kk);
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   s[16], t[16], a[4];
    logic [127:0] res;
`ifdef AES_DEC_KEY_EXPAND_EN
    for (int i = 0; i < 4; i++) w[i] = kk[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = schedF(tmp, i / 4);
      w[i] = w[i-4] ^ tmp;
    end
`else
    for (int i = 0; i < 4; i++) w[40+i] = kk[127-32*i -: 32];
    for (int i = 43; i >= 4; i--) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = schedF(tmp, i / 4);
      w[i-4] = w[i] ^ tmp;
    end
`endif
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*((c+r)%4)] = s[r + 4*c];
      for (int i = 0; i < 16; i++) s[i] = invSbox[t[i]] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[r + 4*c];
          for (int r = 0; r < 4; r++)
            s[r + 4*c] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                         gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      checkVal("clr_out", dout, '0);
      tick();
      lat++;
    end
    checkVal("timeout", 128'(out_valid), 128'd1);
  endtask

  task automatic runBlock(input string tag, input logic [127:0] ct, input logic [127:0] kk,
                          input logic [127:0] exp, input int holdOff);
    int lat;
    din = ct; dkey = kk; in_valid = 1'b1; out_ready = (holdOff == 0);
    tick();
    in_valid = 1'b0;
    din  = {$urandom, $urandom, $urandom, $urandom};
    dkey = {$urandom, $urandom, $urandom, $urandom};
    waitValid(lat);
    checkVal({tag, "_lat"}, 128'(lat), 128'(LAT));
    checkVal({tag, "_out"}, dout, exp);
    for (int i = 0; i < holdOff; i++) begin
      tick();
      checkVal({tag, "_bp_valid"}, 128'(out_valid), 128'd1);
      checkVal({tag, "_bp_out"}, dout, exp);
      checkVal({tag, "_bp_in_ready"}, 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    checkVal({tag, "_released"}, 128'(out_valid), 128'd0);
    checkVal({tag, "_idle"}, 128'(busy), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [127:0] rc, rk;
    initBoxes();
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_in_ready", 128'(in_ready), 128'd1);
    checkVal("rst_out_valid", 128'(out_valid), 128'd0);
    checkVal("rst_busy", 128'(busy), 128'd0);
    checkVal("rst_out", dout, '0);
    rst_n = 1'b1;
    tick();

    runBlock("c1", CT1, K1, PT1, 0);
    runBlock("fipsB", CTB, KB, PTB, 0);
    runBlock("bp", CT1, K1, PT1, 5);

    // Back-to-back: second accept shares the edge of the first out handshake.
    din = CT1; dkey = K1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    din = CTB; dkey = KB;
    waitValid(lat);
    checkVal("b2b_lat1", 128'(lat), 128'(LAT));
    checkVal("b2b_out1", dout, PT1);
    checkVal("b2b_in_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    din = '0; dkey = '0;
    waitValid(lat);
    checkVal("b2b_lat2", 128'(lat), 128'(LAT));
    checkVal("b2b_out2", dout, PTB);
    tick();
    checkVal("b2b_released", 128'(out_valid), 128'd0);

    // Garbage offered while busy must be ignored.
    din = CT1; dkey = K1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    din  = {$urandom, $urandom, $urandom, $urandom};
    dkey = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    checkVal("ign_in_ready", 128'(in_ready), 128'd0);
    checkVal("ign_busy", 128'(busy), 128'd1);
    tick();
    in_valid = 1'b0;
    waitValid(lat);
    checkVal("ign_lat", 128'(lat + 5), 128'(LAT));
    checkVal("ign_out", dout, PT1);
    tick();

    // Asynchronous reset mid-block.
    din = CT1; dkey = K1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checkVal("mrst_out_valid", 128'(out_valid), 128'd0);
    checkVal("mrst_out", dout, '0);
    checkVal("mrst_in_ready", 128'(in_ready), 128'd1);
    checkVal("mrst_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    runBlock("post_rst", CT1, K1, PT1, 0);

    for (int n = 0; n < 20; n++) begin
      rc = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      runBlock("rand", rc, rk, modelDecrypt(rc, rk), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
